// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache.
// Optional build macro DCACHE_PERF_CNT_EN (used in dcache_ctrl) adds hit/miss counters.
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTE_W         = 2;
  localparam int unsigned DEF_LINES      = 8;
  localparam int unsigned DEF_BLOCK_SIZE = 4;

  // Field widths for the default geometry; modules re-derive them from their own parameters.
  localparam int unsigned OFF_W = $clog2(DEF_BLOCK_SIZE);
  localparam int unsigned IDX_W = $clog2(DEF_LINES);
  localparam int unsigned TAG_W = WORD_W - BYTE_W - OFF_W - IDX_W;

  function automatic logic [31:0] block_base(input logic [31:0] addr, input int unsigned block_size);
    return addr & ~(32'(block_size * 4) - 32'd1);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage: valid/tag/data arrays with combinational hit and word read,
// synchronous whole-line fill and single-word write. Only valid bits are reset.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned LINES      = DEF_LINES,
  parameter int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [31:0]              lookup_addr,
  output logic                     hit,
  output logic [31:0]              rd_word,
  input  logic                     fill_en,
  input  logic [31:0]              fill_addr,
  input  logic [32*BLOCK_SIZE-1:0] fill_data,
  input  logic                     wr_en,
  input  logic [31:0]              wr_addr,
  input  logic [31:0]              wr_data
);

  localparam int unsigned OW = $clog2(BLOCK_SIZE);
  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = WORD_W - BYTE_W - OW - IW;

  logic [31:0]   data_q [LINES][BLOCK_SIZE];
  logic [TW-1:0] tag_q  [LINES];
  logic [LINES-1:0] valid_q;

  logic [OW-1:0] lk_off, wr_off;
  logic [IW-1:0] lk_idx, fl_idx, wr_idx;
  logic [TW-1:0] lk_tag, fl_tag;
  logic          unused_bits;

  assign lk_off = lookup_addr[BYTE_W +: OW];
  assign lk_idx = lookup_addr[BYTE_W+OW +: IW];
  assign lk_tag = lookup_addr[31 -: TW];
  assign fl_idx = fill_addr[BYTE_W+OW +: IW];
  assign fl_tag = fill_addr[31 -: TW];
  assign wr_off = wr_addr[BYTE_W +: OW];
  assign wr_idx = wr_addr[BYTE_W+OW +: IW];

  assign unused_bits = ^{lookup_addr[1:0], fill_addr[BYTE_W+OW-1:0], wr_addr[1:0], wr_addr[31 -: TW]};

  assign hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign rd_word = data_q[lk_idx][lk_off];

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fl_idx] <= 1'b1;
    end
  end

  // Fill and single-word write never coincide: the controller issues them from different states.
  always_ff @(posedge Clk) begin
    if (fill_en) begin
      tag_q[fl_idx] <= fl_tag;
      for (int w = 0; w < BLOCK_SIZE; w++) begin
        data_q[fl_idx][w] <= fill_data[32*w +: 32];
      end
    end else if (wr_en) begin
      data_q[wr_idx][wr_off] <= wr_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, write-allocate data cache controller between MEM stage and memory.
// Define DCACHE_PERF_CNT_EN to add the HitCount / MissCount outputs.
//
// state    | meaning
// ST_IDLE  | serve hits; launch a block fill on miss or a write-through on store hit
// ST_FILL  | ReadMiss held until ReadReady, then the line is loaded and the access retried
// ST_WRITE | MemWriteThrough held until WriteReady; the store retires in that cycle
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned LINES      = DEF_LINES,
  parameter int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [31:0]              CpuAddr,
  input  logic                     CpuRead,
  input  logic                     CpuWrite,
  input  logic [31:0]              CpuWriteData,
  output logic [31:0]              CpuReadData,
  output logic                     Stall,
  output logic [31:0]              MemAddress,
  output logic                     ReadMiss,
  output logic                     MemWriteThrough,
  output logic [31:0]              MemWriteData,
  input  logic [32*BLOCK_SIZE-1:0] MemReadData,
  input  logic                     ReadReady,
  input  logic                     WriteReady
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]              HitCount,
  output logic [31:0]              MissCount
`endif
);

  state_t      state_q, state_d;
  logic        rm_q, rm_d;
  logic        mwt_q, mwt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req, hit, fill_en, wr_en;

  assign req = CpuRead | CpuWrite;

  dcache_array #(
    .LINES      (LINES),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_array (
    .Clk         (Clk),
    .Rst         (Rst),
    .lookup_addr (CpuAddr),
    .hit         (hit),
    .rd_word     (CpuReadData),
    .fill_en     (fill_en),
    .fill_addr   (addr_q),
    .fill_data   (MemReadData),
    .wr_en       (wr_en),
    .wr_addr     (CpuAddr),
    .wr_data     (CpuWriteData)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      rm_q    <= 1'b0;
      mwt_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rm_q    <= rm_d;
      mwt_q   <= mwt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rm_d    = rm_q;
    mwt_d   = mwt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    Stall   = 1'b0;
    fill_en = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req && !hit) begin
          Stall   = 1'b1;
          state_d = ST_FILL;
          rm_d    = 1'b1;
          addr_d  = block_base(CpuAddr, BLOCK_SIZE);
        end else if (CpuWrite && hit) begin
          Stall   = 1'b1;
          wr_en   = 1'b1;
          state_d = ST_WRITE;
          mwt_d   = 1'b1;
          addr_d  = {CpuAddr[31:2], 2'b00};
          wdata_d = CpuWriteData;
        end
      end
      ST_FILL: begin
        Stall = 1'b1;
        if (ReadReady) begin
          fill_en = 1'b1;
          rm_d    = 1'b0;
          addr_d  = '0;
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        Stall = !WriteReady;
        if (WriteReady) begin
          mwt_d   = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ReadMiss        = rm_q;
  assign MemWriteThrough = mwt_q;
  assign MemAddress      = addr_q;
  assign MemWriteData    = wdata_q;

`ifdef DCACHE_PERF_CNT_EN
  logic hit_evt, miss_evt;

  // A store hit counts as it enters WRITE; a retried access after a fill is a hit too.
  assign hit_evt  = (state_q == ST_IDLE) && req && hit;
  assign miss_evt = (state_q == ST_IDLE) && req && !hit;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      HitCount  <= '0;
      MissCount <= '0;
    end else begin
      if (hit_evt)  HitCount  <= HitCount + 32'd1;
      if (miss_evt) MissCount <= MissCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus random loads/stores
// against a memory responder and a resident-block / memory-image reference model.
module tb_dcache_ctrl;

  localparam int LINES = 8;
  localparam int BS    = 4;

  logic            Clk = 1'b0;
  logic            Rst;
  logic [31:0]     CpuAddr;
  logic            CpuRead;
  logic            CpuWrite;
  logic [31:0]     CpuWriteData;
  logic [31:0]     CpuReadData;
  logic            Stall;
  logic [31:0]     MemAddress;
  logic            ReadMiss;
  logic            MemWriteThrough;
  logic [31:0]     MemWriteData;
  logic [32*BS-1:0] MemReadData;
  logic            ReadReady;
  logic            WriteReady;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]     HitCount;
  logic [31:0]     MissCount;
`endif

  always #5 Clk = ~Clk;

  dcache_ctrl #(.LINES(LINES), .BLOCK_SIZE(BS)) dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .CpuAddr         (CpuAddr),
    .CpuRead         (CpuRead),
    .CpuWrite        (CpuWrite),
    .CpuWriteData    (CpuWriteData),
    .CpuReadData     (CpuReadData),
    .Stall           (Stall),
    .MemAddress      (MemAddress),
    .ReadMiss        (ReadMiss),
    .MemWriteThrough (MemWriteThrough),
    .MemWriteData    (MemWriteData),
    .MemReadData     (MemReadData),
    .ReadReady       (ReadReady),
    .WriteReady      (WriteReady)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .HitCount        (HitCount),
    .MissCount       (MissCount)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  // memory image held by the responder, and the reference image updated by each store
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  // reference model: which block each cache line currently holds
  logic [31:0] res_blk [LINES];
  bit          res_v   [LINES];
  int          exp_hits   = 0;
  int          exp_misses = 0;

  int          rd_reqs = 0;
  int          wr_reqs = 0;
  logic [31:0] last_rd_addr, last_wr_addr, last_wr_data;
  int          force_lat = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  // memory responder: latches each request, answers after a random latency with a one-cycle pulse
  initial begin : responder
    bit          pend;
    bit          pend_rd;
    int          cnt;
    logic [31:0] pend_addr;
    pend = 0; pend_rd = 0; cnt = 0; pend_addr = '0;
    ReadReady = 1'b0; WriteReady = 1'b0; MemReadData = '0;
    forever begin
      @(negedge Clk);
      ReadReady  = 1'b0;
      WriteReady = 1'b0;
      n_assert++;
      assert (!(ReadMiss === 1'b1 && MemWriteThrough === 1'b1)) else begin
        n_fail++;
        $error("FAIL excl: ReadMiss=%0b MemWriteThrough=%0b, required not both high", ReadMiss, MemWriteThrough);
      end
      if (Rst === 1'b1) begin
        pend = 0;
      end else if (!pend) begin
        if (ReadMiss === 1'b1) begin
          pend = 1; pend_rd = 1; pend_addr = MemAddress;
          rd_reqs++; last_rd_addr = MemAddress;
          cnt = (force_lat > 0) ? force_lat : int'($urandom_range(1, 18));
        end else if (MemWriteThrough === 1'b1) begin
          pend = 1; pend_rd = 0; pend_addr = MemAddress;
          wr_reqs++; last_wr_addr = MemAddress; last_wr_data = MemWriteData;
          cnt = int'($urandom_range(1, 18));
        end
      end else begin
        n_assert++;
        assert (MemAddress === pend_addr && (pend_rd ? ReadMiss : MemWriteThrough) === 1'b1) else begin
          n_fail++;
          $error("FAIL hold: MemAddress=0x%08h req=%0b%0b expected addr=0x%08h held", MemAddress, ReadMiss, MemWriteThrough, pend_addr);
        end
        if (cnt == 0) begin
          pend = 0;
          if (pend_rd) begin
            for (int w = 0; w < BS; w++) begin
              MemReadData[32*w +: 32] = mem[(int'(pend_addr[9:2]) + w) % 256];
            end
            ReadReady = 1'b1;
          end else begin
            mem[pend_addr[9:2]] = last_wr_data;
            WriteReady = 1'b1;
          end
        end else begin
          cnt--;
        end
      end
    end
  end

  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] blk;
    int          idx, cyc, rd0, wr0;
    bit          exp_hit;
    blk     = addr & ~32'(BS*4 - 1);
    idx     = int'(addr[31:4]) % LINES;
    exp_hit = res_v[idx] && (res_blk[idx] == blk);
    rd0 = rd_reqs; wr0 = wr_reqs;
    @(negedge Clk);
    CpuAddr = addr; CpuRead = !wr; CpuWrite = wr; CpuWriteData = wdata;
    #1;
    cyc = 0;
    while (Stall === 1'b1 && cyc < 100) begin
      @(negedge Clk); #1; cyc++;
    end
    chk("timeout", 32'(cyc < 100), 32'd1);
    if (!wr) begin
      chk("load_data", CpuReadData, ref_mem[addr[9:2]]);
      chk("load_stalled", 32'(cyc > 0), 32'(!exp_hit));
    end else begin
      chk("store_stalled", 32'(cyc > 0), 32'd1);
      chk("wt_count", 32'(wr_reqs - wr0), 32'd1);
      chk("wt_addr", last_wr_addr, {addr[31:2], 2'b00});
      chk("wt_data", last_wr_data, wdata);
    end
    chk("fill_count", 32'(rd_reqs - rd0), 32'(!exp_hit));
    if (!exp_hit) chk("fill_addr", last_rd_addr, blk);
    @(posedge Clk); #1;
    CpuRead = 1'b0; CpuWrite = 1'b0;
    exp_hits++;
    if (!exp_hit) begin
      exp_misses++;
      res_v[idx]   = 1'b1;
      res_blk[idx] = blk;
    end
    if (wr) ref_mem[addr[9:2]] = wdata;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rm"},    32'(ReadMiss), 32'd0);
    chk({tag, "_mwt"},   32'(MemWriteThrough), 32'd0);
    chk({tag, "_addr"},  MemAddress, 32'd0);
    chk({tag, "_wdata"}, MemWriteData, 32'd0);
    chk({tag, "_stall"}, 32'(Stall), 32'd0);
  endtask

  initial begin : main
    Rst = 1'b1; CpuAddr = '0; CpuRead = 1'b0; CpuWrite = 1'b0; CpuWriteData = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'hA; mem[5] = 32'hB; mem[6] = 32'hC; mem[7] = 32'hD;
    for (int i = 4; i < 8; i++) ref_mem[i] = mem[i];
    for (int i = 0; i < LINES; i++) begin res_v[i] = 1'b0; res_blk[i] = '0; end

    repeat (3) @(negedge Clk);
    #1 check_idle_outputs("reset");
    @(negedge Clk); #2 Rst = 1'b0;

    // cold load, hit in the same line, store hit, reload
    access(0, 32'h10, '0);
    access(0, 32'h18, '0);
    access(1, 32'h14, 32'h55);
    access(0, 32'h14, '0);
    // store miss allocates then writes through
    access(1, 32'h40, 32'h99);
    access(0, 32'h40, '0);
    // conflict on index 0
    access(0, 32'h00, '0);
    access(0, 32'h80, '0);
    access(0, 32'h00, '0);
    #1 check_idle_outputs("idle");

`ifdef DCACHE_PERF_CNT_EN
    chk("hit_count", HitCount, 32'(exp_hits));
    chk("miss_count", MissCount, 32'(exp_misses));
`endif

    // reset in the middle of a fill
    force_lat = 15;
    @(negedge Clk);
    CpuAddr = 32'h200; CpuRead = 1'b1;
    repeat (3) @(negedge Clk);
    chk("fill_pending", 32'(ReadMiss), 32'd1);
    #2 Rst = 1'b1;
    #1;
    chk("rst_rm", 32'(ReadMiss), 32'd0);
    chk("rst_addr", MemAddress, 32'd0);
    chk("rst_stall", 32'(Stall), 32'd1);
    CpuRead = 1'b0;
    @(negedge Clk); #2 Rst = 1'b0;
    force_lat = 0;
    for (int i = 0; i < LINES; i++) res_v[i] = 1'b0;
    exp_hits = 0; exp_misses = 0;
`ifdef DCACHE_PERF_CNT_EN
    chk("rst_hit_count", HitCount, 32'd0);
`endif
    access(0, 32'h18, '0);
    access(0, 32'h14, '0);

    // random traffic over a window that aliases every index several times
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 2) == 0) access(1, a, $urandom);
      else                           access(0, a, '0);
    end

`ifdef DCACHE_PERF_CNT_EN
    chk("hit_count_end", HitCount, 32'(exp_hits));
    chk("miss_count_end", MissCount, 32'(exp_misses));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
